// File: rtl/buffer_pkg.sv
// Shared defaults and helpers for the K-in/J-out circular buffer pointer controller.
package buffer_pkg;

  localparam int BUF_SIZE = 16;
  localparam int BUF_K    = 4;
  localparam int BUF_J    = 4;

  // Per-cycle handshake outcome.
  typedef struct packed {
    logic push;
    logic pop;
  } xfer_t;

  // An occupancy counter must hold 0..SIZE inclusive.
  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/buffer_ptr_ctrl_wrap_ptr.sv
// Circular address register that advances by STEP words and wraps by truncation.
module wrap_ptr #(
  parameter int BIT  = 4,
  parameter int STEP = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           adv,
  output logic [BIT-1:0] ptr
);

  // One extra bit so STEP == SIZE does not overflow before truncation.
  localparam logic [BIT:0] STEP_W = (BIT+1)'(STEP);

  logic [BIT:0] sum;

  assign sum = {1'b0, ptr} + STEP_W;

  always_ff @(posedge clk) begin
    if (!rst)     ptr <= '0;
    else if (clr) ptr <= '0;
    else if (adv) ptr <= sum[BIT-1:0];
  end

endmodule

// File: rtl/buffer_ptr_ctrl.sv
// Pointer/occupancy controller: K-word pushes, J-word pops, full/empty status.
module buffer_ptr_ctrl
  import buffer_pkg::*;
#(
  parameter int SIZE = BUF_SIZE,
  parameter int K    = BUF_K,
  parameter int J    = BUF_J,
  parameter int BIT  = $clog2(SIZE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ld,
  output logic [BIT-1:0] write_add,
  output logic [BIT-1:0] read_add,
  output logic [BIT:0] count,
  output logic         full,
  output logic         empty
);

  localparam int CW = cnt_width(SIZE);

  localparam logic [BIT+1:0] K_X    = (BIT+2)'(K);
  localparam logic [BIT+1:0] SIZE_X = (BIT+2)'(SIZE);
  localparam logic [CW-1:0]  K_C    = CW'(K);
  localparam logic [CW-1:0]  J_C    = CW'(J);
  localparam logic [CW-1:0]  SIZE_C = CW'(SIZE);

  logic [CW-1:0] cnt;
  logic [CW-1:0] add_k, sub_j;
  xfer_t         xf;

  // Readiness depends on registered occupancy only, never on the partner's handshake.
  assign in_ready  = ({{(BIT+2-CW){1'b0}}, cnt} + K_X) <= SIZE_X;
  assign out_valid = cnt >= J_C;

  assign xf.push = in_valid & in_ready;
  assign xf.pop  = out_valid & out_ready;
  assign ld      = xf.push;

  assign add_k = xf.push ? K_C : '0;
  assign sub_j = xf.pop  ? J_C : '0;

  always_ff @(posedge clk) begin
    if (!rst)       cnt <= '0;
    else if (flush) cnt <= '0;
    else            cnt <= cnt + add_k - sub_j;
  end

  wrap_ptr #(.BIT(BIT), .STEP(K)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (xf.push),
    .ptr (write_add)
  );

  wrap_ptr #(.BIT(BIT), .STEP(J)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (xf.pop),
    .ptr (read_add)
  );

  assign count = cnt;
  assign full  = cnt == SIZE_C;
  assign empty = cnt == '0;

endmodule

// File: tb/tb_buffer_ptr_ctrl.sv
// Randomized and directed bench for buffer_ptr_ctrl against a word-queue reference model.
module tb_buffer_ptr_ctrl;

  localparam int SIZE = 16;
  localparam int K    = 4;
  localparam int J    = 4;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic       in_ready, out_valid, ld, full, empty;
  logic [3:0] write_add, read_add;
  logic [4:0] count;

  logic       b_rst, b_flush, b_in_valid, b_out_ready;
  logic       b_in_ready, b_out_valid, b_ld, b_full, b_empty;
  logic [3:0] b_write_add, b_read_add;
  logic [4:0] b_count;

  int checks = 0;
  int errors = 0;

  // Reference: the stored words in order, plus modular pointers.
  int unsigned q[$];
  int unsigned mem [SIZE];
  int m_wp, m_rp;

  always #5 clk = ~clk;

  buffer_ptr_ctrl #(.SIZE(SIZE), .K(K), .J(J)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .ld(ld), .write_add(write_add),
    .read_add(read_add), .count(count), .full(full), .empty(empty)
  );

  buffer_ptr_ctrl #(.SIZE(SIZE), .K(4), .J(2)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .ld(b_ld), .write_add(b_write_add),
    .read_add(b_read_add), .count(b_count), .full(b_full), .empty(b_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle on the main DUT; called just after a rising edge.
  task automatic step(input bit iv, input bit ordy, input bit fl, input bit rs, input bit do_chk);
    int  c;
    bit  e_ir, e_ov, push, pop;
    in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
    #1;
    c    = q.size();
    e_ir = (c + K) <= SIZE;
    e_ov = c >= J;
    push = iv && e_ir;
    pop  = ordy && e_ov;
    if (do_chk) begin
      check("in_ready",  in_ready,  e_ir);
      check("out_valid", out_valid, e_ov);
      check("ld",        ld,        push);
      check("write_add", write_add, m_wp);
      check("read_add",  read_add,  m_rp);
      check("count",     count,     c);
      check("full",      full,      c == SIZE);
      check("empty",     empty,     c == 0);
      if (e_ov)
        for (int i = 0; i < J; i++)
          check("par_out", mem[(int'(read_add) + i) % SIZE], q[i]);
    end
    @(posedge clk);
    #1;
    if (!rs || fl) begin
      q.delete(); m_wp = 0; m_rp = 0;
    end else begin
      if (pop) begin
        for (int i = 0; i < J; i++) void'(q.pop_front());
        m_rp = (m_rp + J) % SIZE;
      end
      if (push) begin
        for (int i = 0; i < K; i++) begin
          int unsigned w;
          w = $urandom;
          mem[(m_wp + i) % SIZE] = w;
          q.push_back(w);
        end
        m_wp = (m_wp + K) % SIZE;
      end
    end
  endtask

  initial begin
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    b_rst = 0; b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    m_wp = 0; m_rp = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    b_rst = 1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_wa", write_add, 0);
    check("rst_ra", read_add, 0);

    // Fill
    for (int i = 0; i < 4; i++) begin
      check("fill_wa", write_add, 4 * i);
      step(1, 0, 0, 1, 1);
    end
    check("fill_wa_wrap", write_add, 0);
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_in_ready", in_ready, 0);
    step(1, 0, 0, 1, 1);
    check("fill_count_hold", count, 16);

    // Wrap: reach rd=12, cnt=8, then pop across 15->0
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    check("pre_wrap_ra", read_add, 12);
    check("pre_wrap_count", count, 8);
    step(0, 1, 0, 1, 1);
    check("wrap_ra", read_add, 0);
    check("wrap_count", count, 4);

    // Simultaneous push and pop
    step(1, 0, 0, 1, 1);
    check("sim_pre", count, 8);
    step(1, 1, 0, 1, 1);
    check("sim_count", count, 8);
    check("sim_wa", write_add, 12);
    check("sim_ra", read_add, 4);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    check("sim_full", count, 16);
    step(1, 1, 0, 1, 1);
    check("full_pop_only", count, 12);

    // Flush, then reset, coinciding with push and pop at cnt=8
    step(0, 1, 0, 1, 1);
    check("pre_flush", count, 8);
    step(1, 1, 1, 1, 1);
    check("flush_count", count, 0);
    check("flush_wa", write_add, 0);
    check("flush_ra", read_add, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    check("pre_rst", count, 8);
    step(1, 1, 0, 0, 1);
    check("mid_rst_count", count, 0);
    check("mid_rst_wa", write_add, 0);
    check("mid_rst_ra", read_add, 0);

    // Random traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 60) != 0, 1);
    step(0, 0, 0, 1, 1);

    // Asymmetric K=4, J=2
    b_in_valid = 1;
    @(posedge clk); #1;
    b_in_valid = 0;
    check("asym_out_valid", b_out_valid, 1);
    check("asym_count", b_count, 4);
    check("asym_ra0", b_read_add, 0);
    b_out_ready = 1;
    @(posedge clk); #1;
    check("asym_ra1", b_read_add, 2);
    check("asym_count1", b_count, 2);
    @(posedge clk); #1;
    check("asym_ra2", b_read_add, 4);
    check("asym_count2", b_count, 0);
    check("asym_empty", b_empty, 1);
    check("asym_out_valid0", b_out_valid, 0);
    b_out_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
